core_fetch: RTL and testbench
=============================

# core_fetch

Instruction fetch stage, directly upstream of decode/execute. Holds the fetch PC, issues word requests to the instruction memory port, and buffers returned instructions with their PCs for decode. Consumes the execute stage's redirect (`i_pc_src` / `i_pc_target`) and discards every in-flight fetch from the wrong path.

## Interface
- `RESET_VEC`, default 32'h0000_0000: first fetch address; bits [1:0] ignored.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_pc_src`  in  1  redirect strobe from execute; one cycle per taken jump/branch.
- `i_pc_target`  in  [31:2]  redirect word address; valid with `i_pc_src`.
- `o_imem_req`  out  1  fetch request.
- `o_imem_addr`  out  [31:2]  request word address.
- `i_imem_gnt`  in  1  request accepted this cycle (sampled with `o_imem_req`).
- `i_imem_rvalid`  in  1  response valid; responses return in request order, latency ≥1 cycle.
- `i_imem_rdata`  in  32  instruction word.
- `o_valid`  out  1  instruction available to decode.
- `o_instr`  out  32  instruction.
- `o_pc`  out  [31:2]  PC of `o_instr`.
- `i_ready`  in  1  decode accepts; transfer when `o_valid & i_ready`.

## Operation
- State: `pc_fetch` [31:2], `in_flight` (0..2), `discard` (0..2), 2-entry PC-tag FIFO, 2-entry output FIFO {pc, instr}.
- Issue: `o_imem_req = !i_reset & !i_pc_src & (in_flight + out_count - pop < 2)`, with `pop = o_valid & i_ready`. `o_imem_addr = pc_fetch`.
- The memory port has no hold rule: `req` may drop without `gnt`, and the address may change while `gnt` is low.
- On `req & gnt`: `pc_fetch <= pc_fetch + 1` (30-bit wrap), push `pc_fetch` to the tag FIFO, `in_flight++`.
- On `rvalid`: pop the tag FIFO and decrement `in_flight`. If `discard != 0`, decrement `discard` and drop the data. Otherwise push {tag, rdata} to the output FIFO.
- Simultaneous grant and rvalid: `in_flight` is unchanged.
- The credit rule guarantees the output FIFO never overflows. An `rvalid` with `in_flight == 0` is a protocol error and is ignored.
- Redirect (`i_pc_src`):
  - `pc_fetch <= i_pc_target`.
  - Output FIFO is flushed.
  - `discard <= in_flight - (rvalid ? 1 : 0)`. A response arriving in the redirect cycle is itself dropped.
  - No request is issued.
  - `o_valid` is forced 0 in the same cycle (combinational gate).
- Redirect has priority over push and pop. An `i_ready` in a redirect cycle is ignored.
- `o_valid = (out_count != 0) & !i_pc_src`. `o_instr` and `o_pc` come from the FIFO head and are held stable while `o_valid & !i_ready`.
- Reset state:
  - `pc_fetch = RESET_VEC[31:2]`.
  - All counters 0; both FIFOs empty.
  - `o_valid = 0`, `o_imem_req = 0`, `o_imem_addr = RESET_VEC[31:2]`, `o_instr = 0`, `o_pc = 0`.
  - Reset mid-operation abandons outstanding responses. The memory is reset on the same `i_reset`.

## Timing
- Cycle R: first cycle with `i_reset` low. `o_imem_req = 1` at `RESET_VEC`.
- With 1-cycle memory: rvalid at R+1, `o_valid` at R+2 (output FIFO is registered, no bypass).
- Redirect at cycle N: request to the target at N+1. With 1-cycle memory, `o_valid` at N+3 (2 bubble cycles after N).
- Throughput: sustained 1 instruction/cycle with 1-cycle memory and `i_ready` held high.
- Decode stall: at most 2 outstanding plus buffered entries; requests stop until a pop.

## Configuration
- `CORE_FETCH_PERF_EN` defined: adds two outputs.
  - `o_perf_fetched` [31:0]: count of `o_valid & i_ready`.
  - `o_perf_bubble` [31:0]: count of cycles with `!o_valid & i_ready`.
  - Both reset to 0 and wrap.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared core package: `fetch_entry_t` struct {pc [31:2], instr [31:0]} and the default reset-vector constant. `rv_defines.vh` remains the include for opcode-level defines.
- One sub-module, `core_fetch_fifo`: 2-entry synchronous FIFO, parameterised width, push/pop/flush, count output. Instantiated twice (tag FIFO width 30; output FIFO of `fetch_entry_t`).

## Test plan
- Reset release, `RESET_VEC` = 0x100, 1-cycle memory, `i_ready` = 1 → addresses 0x40, 0x41, 0x42 (word) on consecutive cycles; `o_pc` 0x40, 0x41, … from R+2, one per cycle.
- `i_ready` low for 5 cycles → at most 2 entries buffered, `o_imem_req` = 0 once credit is exhausted; `o_instr`/`o_pc` stable; resume with no loss or duplication.
- Redirect to 0x200 while 2 fetches are in flight (3-cycle memory) → both responses dropped, next `o_pc` = 0x200, `discard` returns to 0.
- Redirect in the same cycle as `rvalid` and `gnt` low → that response dropped, `o_valid` = 0 that cycle, request to target the next cycle.
- Random `gnt`/`rvalid` latency (1–4) with random `i_ready` → delivered PC stream is strictly sequential between redirects and matches a reference model; no FIFO overflow.
- With `CORE_FETCH_PERF_EN`: 10 transfers plus 3 bubble cycles → `o_perf_fetched` = 10, `o_perf_bubble` = 3; `i_reset` clears both to 0.

Source files
------------

// File: rtl/core_fetch_pkg.sv
// core_fetch_pkg: shared fetch types and the default reset vector.
package core_fetch_pkg;
  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
endpackage

// File: rtl/core_fetch_fifo.sv
// core_fetch_fifo: 2-entry synchronous FIFO with flush and occupancy count.
module core_fetch_fifo #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_rd, r_wr;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;
  assign w_pop   = i_pop & (r_cnt != 2'd0);
  assign w_push  = i_push & ((r_cnt != 2'd2) | w_pop);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage with redirect squash and a 2-entry decode buffer.
// Optional CORE_FETCH_PERF_EN adds fetched/bubble performance counters.
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_src,
  input  logic [31:2] i_pc_target,
  output logic        o_imem_req,
  output logic [31:2] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:2] o_pc,
  input  logic        i_ready
`ifdef CORE_FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_bubble
`endif
);
  logic [31:2]  r_pc_fetch;
  logic [1:0]   r_in_flight, r_discard;
  logic [1:0]   w_out_cnt, w_tag_cnt;
  logic [31:2]  w_tag;
  fetch_entry_t w_head, w_entry;
  logic         w_pop, w_fire, w_rsp, w_keep;
  assign w_pop       = o_valid & i_ready;
  assign o_valid     = (w_out_cnt != 2'd0) & !i_pc_src;
  // Credit counts outstanding plus buffered entries, so the output FIFO cannot overflow.
  assign o_imem_req  = !i_reset & !i_pc_src &
                       (({1'b0, r_in_flight} + {1'b0, w_out_cnt} - {2'b0, w_pop}) < 3'd2);
  assign o_imem_addr = r_pc_fetch;
  assign w_fire      = o_imem_req & i_imem_gnt;
  assign w_rsp       = i_imem_rvalid & (w_tag_cnt != 2'd0);
  assign w_keep      = w_rsp & (r_discard == 2'd0) & !i_pc_src;
  assign w_entry     = '{pc: w_tag, instr: i_imem_rdata};
  assign o_pc        = w_head.pc;
  assign o_instr     = w_head.instr;
  core_fetch_fifo #(.W(30)) u_tag (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(w_fire), .i_pop(w_rsp), .i_flush(1'b0),
    .i_data(r_pc_fetch), .o_data(w_tag), .o_count(w_tag_cnt)
  );
  core_fetch_fifo #(.W($bits(fetch_entry_t))) u_out (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(w_keep), .i_pop(w_pop), .i_flush(i_pc_src),
    .i_data(w_entry), .o_data(w_head), .o_count(w_out_cnt)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc_fetch  <= RESET_VEC[31:2];
      r_in_flight <= 2'd0;
      r_discard   <= 2'd0;
    end else begin
      r_pc_fetch  <= i_pc_src ? i_pc_target : w_fire ? r_pc_fetch + 30'd1 : r_pc_fetch;
      r_in_flight <= r_in_flight + {1'b0, w_fire} - {1'b0, w_rsp};
      r_discard   <= i_pc_src ? r_in_flight - {1'b0, w_rsp} :
                     (w_rsp && r_discard != 2'd0) ? r_discard - 2'd1 : r_discard;
    end
  end
`ifdef CORE_FETCH_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_perf_fetched <= '0;
      o_perf_bubble  <= '0;
    end else begin
      o_perf_fetched <= o_perf_fetched + {31'b0, w_pop};
      o_perf_bubble  <= o_perf_bubble + {31'b0, !o_valid & i_ready};
    end
  end
`endif
endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: directed and random checks of core_fetch against an in-order memory model and PC scoreboard.
module tb_core_fetch;
  import core_fetch_pkg::*;
  localparam logic [31:0] RV = 32'h100;
  typedef struct {logic [31:2] addr; int due;} req_t;
  logic        i_clk = 0, i_reset = 1, i_pc_src = 0, i_imem_gnt = 1, i_imem_rvalid = 0, i_ready = 0;
  logic [31:2] i_pc_target = '0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_imem_req, o_valid;
  logic [31:2] o_imem_addr, o_pc;
  logic [31:0] o_instr;
`ifdef CORE_FETCH_PERF_EN
  logic [31:0] o_perf_fetched, o_perf_bubble;
`endif
  req_t         mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:2]  exp_next;
  int           cyc = 0, checks = 0, errors = 0, lat = 1, transfers = 0, t0, n;
  bit           rnd_gnt = 0;

  core_fetch #(.RESET_VEC(RV)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc_src(i_pc_src), .i_pc_target(i_pc_target),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata), .o_valid(o_valid),
    .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready)
`ifdef CORE_FETCH_PERF_EN
    , .o_perf_fetched(o_perf_fetched), .o_perf_bubble(o_perf_bubble)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] insn(input logic [31:2] a);
    return {a, 2'b11} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: exp_next, instr: insn(exp_next)});
      exp_next++;
    end
  endtask

  task automatic restart(input logic [31:2] a);
    exp_q.delete();
    exp_next = a;
    refill();
  endtask

  // Drive memory outputs for this cycle, then let combinational outputs settle.
  task automatic prep();
    i_imem_rvalid = 0;
    i_imem_rdata  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      i_imem_rvalid = 1;
      i_imem_rdata  = insn(mem_q[0].addr);
    end
    if (rnd_gnt) i_imem_gnt = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  // Scoreboard and memory bookkeeping for the settled cycle, then advance one clock.
  task automatic tick();
    if (i_reset) begin
      mem_q.delete();
      restart(RV[31:2]);
    end else begin
      if (i_pc_src) begin
        chk("redirect_valid_gate", o_valid, 0);
        chk("redirect_no_req", o_imem_req, 0);
        restart(i_pc_target);
      end else if (o_valid && i_ready) begin
        transfers++;
        chk("sb_entry", {o_pc, o_instr}, exp_q.pop_front());
        refill();
      end
      if (o_imem_req && i_imem_gnt) mem_q.push_back('{addr: o_imem_addr, due: cyc + lat});
      if (i_imem_rvalid) void'(mem_q.pop_front());
    end
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic do_reset(input int k);
    i_reset  = 1;
    i_pc_src = 0;
    repeat (k) begin prep(); tick(); end
    i_reset = 0;
  endtask

  initial begin
    @(negedge i_clk);
    // Reset values
    i_reset = 1;
    prep(); tick();
    prep();
    chk("rst_valid", o_valid, 0);
    chk("rst_req", o_imem_req, 0);
    chk("rst_addr", o_imem_addr, 30'h40);
    chk("rst_instr", o_instr, 0);
    chk("rst_pc", o_pc, 0);
    tick();
    i_reset = 0;
    // Startup timing with 1-cycle memory
    i_ready = 1;
    prep(); chk("r_req", o_imem_req, 1); chk("r_addr", o_imem_addr, 30'h40); tick();
    prep(); chk("r1_addr", o_imem_addr, 30'h41); chk("r1_valid", o_valid, 0); tick();
    prep(); chk("r2_valid", o_valid, 1); chk("r2_pc", o_pc, 30'h40); chk("r2_addr", o_imem_addr, 30'h42); tick();
    prep(); chk("r3_pc", o_pc, 30'h41); tick();
    t0 = transfers;
    repeat (10) begin prep(); tick(); end
    chk("throughput", transfers - t0, 10);
    // Decode stall
    i_ready = 0;
    prep(); chk("stall_req0", o_imem_req, 0); tick();
    repeat (4) begin
      prep();
      chk("stall_valid", o_valid, 1);
      chk("stall_pc", o_pc, exp_q[0].pc);
      chk("stall_instr", o_instr, exp_q[0].instr);
      chk("stall_req", o_imem_req, 0);
      tick();
    end
    chk("stall_buffered", dut.w_out_cnt, 2);
    i_ready = 1;
    repeat (8) begin prep(); tick(); end
    // Redirect with two fetches in flight, 3-cycle memory
    lat = 3;
    do_reset(2);
    prep(); tick();
    prep(); tick();
    i_pc_src = 1; i_pc_target = 30'h80;
    prep(); tick();
    i_pc_src = 0;
    n = 0;
    prep();
    while (!o_valid && n < 20) begin tick(); prep(); n++; end
    chk("redir_timeout", n < 20, 1);
    chk("redir_first_pc", o_pc, 30'h80);
    chk("redir_discard", dut.r_discard, 0);
    tick();
    repeat (6) begin prep(); tick(); end
    // Redirect in the same cycle as rvalid, grant low
    lat = 1;
    do_reset(2);
    repeat (5) begin prep(); tick(); end
    i_pc_src = 1; i_pc_target = 30'hC0; i_imem_gnt = 0;
    prep(); tick();
    i_pc_src = 0; i_imem_gnt = 1;
    prep();
    chk("n1_req", o_imem_req, 1);
    chk("n1_addr", o_imem_addr, 30'hC0);
    chk("n1_valid", o_valid, 0);
    chk("n1_discard", dut.r_discard, 0);
    tick();
    prep(); chk("n2_valid", o_valid, 0); tick();
    prep(); chk("n3_valid", o_valid, 1); chk("n3_pc", o_pc, 30'hC0); tick();
    // Random grant, latency, ready and redirects
    do_reset(2);
    rnd_gnt = 1;
    t0 = transfers;
    repeat (1500) begin
      lat = $urandom_range(1, 4);
      i_ready = ($urandom_range(0, 3) != 0);
      i_pc_src = ($urandom_range(0, 39) == 0);
      if (i_pc_src) i_pc_target = 30'($urandom());
      prep(); tick();
    end
    i_pc_src = 0;
    rnd_gnt = 0;
    i_imem_gnt = 1;
    chk("random_progress", (transfers - t0) > 150, 1);
`ifdef CORE_FETCH_PERF_EN
    lat = 1;
    i_ready = 0;
    do_reset(2);
    prep(); tick();
    i_ready = 1;
    prep(); tick();
    repeat (10) begin prep(); tick(); end
    i_ready = 0; i_pc_src = 1; i_pc_target = 30'h10;
    prep(); tick();
    i_pc_src = 0; i_ready = 1;
    repeat (2) begin prep(); tick(); end
    i_ready = 0;
    prep();
    chk("perf_fetched", o_perf_fetched, 10);
    chk("perf_bubble", o_perf_bubble, 3);
    tick();
    i_reset = 1;
    prep(); tick();
    prep();
    chk("perf_fetched_rst", o_perf_fetched, 0);
    chk("perf_bubble_rst", o_perf_bubble, 0);
    tick();
    i_reset = 0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
